// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the 7-segment scan reader.
//   seg_t            : segment pattern, [0]=a ... [6]=g, active-high
//   nibble_t         : decoded hex digit
//   SEG_0 .. SEG_F   : legal hex glyphs
//   seg7_to_hex()    : seg_t -> {err, nibble}; unknown patterns (blank too) give {1, 0}
//   strobe_state_e   : strobe qualifier FSM states
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

  typedef enum logic [1:0] {
    StWait,
    StCount,
    StHeld
  } strobe_state_e;

  function automatic logic [4:0] seg7_to_hex(input seg_t seg);
    logic [4:0] res;
    res = {1'b1, 4'h0};
    case (seg)
      SEG_0:   res = {1'b0, 4'h0};
      SEG_1:   res = {1'b0, 4'h1};
      SEG_2:   res = {1'b0, 4'h2};
      SEG_3:   res = {1'b0, 4'h3};
      SEG_4:   res = {1'b0, 4'h4};
      SEG_5:   res = {1'b0, 4'h5};
      SEG_6:   res = {1'b0, 4'h6};
      SEG_7:   res = {1'b0, 4'h7};
      SEG_8:   res = {1'b0, 4'h8};
      SEG_9:   res = {1'b0, 4'h9};
      SEG_A:   res = {1'b0, 4'hA};
      SEG_B:   res = {1'b0, 4'hB};
      SEG_C:   res = {1'b0, 4'hC};
      SEG_D:   res = {1'b0, 4'hD};
      SEG_E:   res = {1'b0, 4'hE};
      SEG_F:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph to hex nibble decoder.
//   seg_i : segment pattern
//   nib_o : decoded nibble (0 when illegal)
//   err_o : 1 when seg_i is not a legal hex glyph
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_t    seg_i,
  output nibble_t nib_o,
  output logic    err_o
);

  assign {err_o, nib_o} = seg7_to_hex(seg_i);

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 7-segment display bus and rebuilds complete hex frames.
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_in      : segment lines, [0]=a ... [6]=g
//   dig_in      : one-hot digit strobes, [0]=rightmost digit
//   frame_data  : decoded nibbles, digit i at [4*i+3:4*i]
//   frame_err   : per-digit illegal glyph flag
//   frame_valid : frame_data/frame_err hold a complete frame
//   frame_ready : consumer accepts when frame_valid & frame_ready
//   overrun     : 1-cycle pulse, completed frame dropped because output was occupied
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_in,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  // Synchronizer plus one extra stage used to detect pair changes.
  seg_t                  seg_meta_q, seg_s_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] dig_meta_q, dig_s_q, dig_prev_q;

  strobe_state_e         state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [NUM_DIGITS-1:0][3:0] slot_nib_q, slot_nib_d;
  logic [NUM_DIGITS-1:0]      slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic [NUM_DIGITS-1:0][3:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]      err_q, err_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic                  dig_onehot;
  logic                  pair_changed;
  logic                  capture;
  logic [IdxW-1:0]       idx;
  logic [NUM_DIGITS-1:0] seen_set;
  nibble_t               dec_nib;
  logic                  dec_err;

  seg7_glyph_decode u_decode (
    .seg_i (seg_s_q),
    .nib_o (dec_nib),
    .err_o (dec_err)
  );

  // Zero or multi-hot strobes are treated as blanking.
  assign dig_onehot   = ($countones(dig_s_q) == 1);
  assign pair_changed = (seg_s_q != seg_prev_q) || (dig_s_q != dig_prev_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (dig_s_q[i]) idx = IdxW'(i);
    end
  end

  // Strobe qualifier: one capture per pair held STABLE_CYCLES synced cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StWait: begin
        if (dig_onehot) begin
          state_d = StCount;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StCount: begin
        if (!dig_onehot) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (pair_changed) begin
          cnt_d = CntOne;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (pair_changed) begin
          if (dig_onehot) begin
            state_d = StCount;
            cnt_d   = CntOne;
          end else begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
    // Reaching the threshold this cycle (including cnt=1 when STABLE_CYCLES=1) captures.
    if (state_d == StCount && cnt_d == CntMax) begin
      capture = 1'b1;
      state_d = StHeld;
    end
  end

  // Slot write, frame completion and output handshake.
  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
    seen_d     = seen_q;
    data_d     = data_q;
    err_d      = err_q;
    valid_d    = valid_q && !frame_ready;
    overrun_d  = 1'b0;
    seen_set   = seen_q;
    if (capture) begin
      slot_nib_d[idx] = dec_nib;
      slot_err_d[idx] = dec_err;
      seen_set[idx]   = 1'b1;
      if (&seen_set) begin
        seen_d = '0;
        if (!valid_q || frame_ready) begin
          data_d  = slot_nib_d;
          err_d   = slot_err_d;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        seen_d = seen_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q <= '0;
      seg_s_q    <= '0;
      seg_prev_q <= '0;
      dig_meta_q <= '0;
      dig_s_q    <= '0;
      dig_prev_q <= '0;
      state_q    <= StWait;
      cnt_q      <= '0;
      slot_nib_q <= '0;
      slot_err_q <= '0;
      seen_q     <= '0;
      data_q     <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      seg_meta_q <= seg_in;
      seg_s_q    <= seg_meta_q;
      seg_prev_q <= seg_s_q;
      dig_meta_q <= dig_in;
      dig_s_q    <= dig_meta_q;
      dig_prev_q <= dig_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_nib_q <= slot_nib_d;
      slot_err_q <= slot_err_d;
      seen_q     <= seen_d;
      data_q     <= data_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_err   = err_q;
  assign frame_valid = valid_q;
  assign overrun     = overrun_q;

endmodule
